dmem_slave: RTL and testbench
=============================

DMEM_SLAVE -- requirements
Module: dmem_slave

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as follows.
REQ-002 Parameter DEPTH, default 1024: number of 32-bit words in the array.
REQ-003 Parameter LATENCY, default 2, legal range 1..15: number of BUSY cycles per access.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req  in  1  CPU data access request; held stable by the CPU while stall=1.
REQ-007 we  in  1  1 = write, 0 = read.
REQ-008 be  in  4  byte enables for writes; be[i] selects wdata[8i+7:8i].
REQ-009 addr  in  32  byte address (the CPU's ALUOutM).
REQ-010 wdata  in  32  write data (the CPU's WriteDataM).
REQ-011 rdata  out  32  read data, registered.
REQ-012 stall  out  1  freezes the CPU pipeline while an access is in flight.
REQ-013 resp_valid  out  1  one-cycle completion pulse.
REQ-014 addr_err  out  1  completed access was illegal; valid only when resp_valid=1.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-016 IDLE: stall = req, combinationally.
- When req=1, the block SHALL capture we, be, addr and wdata.
- It SHALL load cnt with LATENCY-1 and go to BUSY.
REQ-017 BUSY: stall=1.
- When cnt≠0, the block SHALL decrement cnt.
- When cnt=0, the block SHALL perform the captured access and go to DONE.
REQ-018 DONE: stall=0 and resp_valid=1 for exactly one cycle, then the FSM SHALL go to IDLE unconditionally.
REQ-019 Timing: first req cycle to the resp_valid cycle SHALL be LATENCY+1 cycles, with stall=1 throughout those LATENCY+1 cycles.
REQ-020 The word index SHALL be addr[31:2].
- An index ≥ DEPTH is out of range.
- Out of range SHALL give addr_err=1, suppress the write, and load rdata with 0.
REQ-021 A write SHALL update only the bytes whose be bit is set.
- be=4'b0000 SHALL complete the full handshake with no array change.
REQ-022 A read SHALL load rdata with the full word when entering DONE.
- rdata SHALL hold that value until the next read completes; writes SHALL NOT alter rdata.
REQ-023 Request inputs SHALL be ignored in BUSY and DONE.
- A req still high in DONE is the completed request, not a new one.
- A new request is recognised only in IDLE.
REQ-024 Back-to-back requests SHALL each incur the full latency; the block does not forward between accesses.

Reset
REQ-025 rst=1 SHALL force:
- FSM state = IDLE
- cnt = 0
- rdata = 0
- resp_valid = 0
- addr_err = 0
- all captured request registers = 0
REQ-026 In IDLE after reset, stall SHALL follow req (per REQ-016).
REQ-027 Reset during BUSY SHALL abort the access; a pending write SHALL NOT reach the array.
REQ-028 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-029 The macro DMEM_ALIGN_CHECK_EN SHALL control misalignment checking.
- Defined: a misaligned access SHALL be treated as an error, with the same handling as out of range (addr_err=1, write suppressed, rdata=0).
- Misaligned means: addr[1:0]≠0 with be=4'b1111, or addr[0]≠0 with be ∈ {4'b0011, 4'b1100}.
- Undefined: addr[1:0] SHALL be ignored, and addr_err SHALL flag out-of-range only.

Structure
REQ-030 Package dmem_pkg SHALL hold:
- the state enum (IDLE, BUSY, DONE)
- WORD_W=32 and BE_W=4
- the cnt width constant (4 bits)
REQ-031 The array SHALL be a sub-module dmem_ram with one synchronous port, per-byte write enables, and a synchronous read.
- dmem_slave SHALL issue the read in the last BUSY cycle.
- The read data SHALL be registered into rdata on entry to DONE.

Verification
REQ-032 Read, LATENCY=2, word 0x10 preloaded with 0xDEADBEEF: req=1, we=0, addr=0x40 -> stall=1 for 3 cycles, then resp_valid=1 with rdata=0xDEADBEEF and addr_err=0.
REQ-033 Byte write to word 0x10 holding 0xDEADBEEF: we=1, be=4'b0100, wdata=0x00AA0000, addr=0x40, then read 0x40 -> rdata=0xDEAABEEF.
REQ-034 Out of range, DEPTH=1024: write to addr=0x00001000 -> addr_err=1 on resp_valid; a following read of addr=0x0 returns its prior value unchanged.
REQ-035 Reset mid-access: write 0x12345678 to addr=0x8 with rst=1 in the first BUSY cycle -> next cycle state IDLE and stall=0 with req=0; a read of 0x8 returns the old value.
REQ-036 Back-to-back, LATENCY=1: read 0x0, then on the next IDLE cycle read 0x4 -> two resp_valid pulses 3 cycles apart, each preceded by 2 stall cycles.
REQ-037 With DMEM_ALIGN_CHECK_EN defined: read at addr=0x42 with be=4'b1111 -> addr_err=1 and rdata=0. Without the macro: the same read returns word 0x10.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory slave.
// Misalignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } stateT;

    // Full-word access must be word aligned; half-word access must be half aligned.
    function automatic logic isMisaligned(input logic [1:0] addrLo, input logic [BE_W-1:0] be);
        return ((be == 4'b1111) && (addrLo != 2'b00)) ||
               (((be == 4'b0011) || (be == 4'b1100)) && addrLo[0]);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word array with per-byte write enables and a registered synchronous read.
// The read register doubles as the slave's rdata holding register.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BE_W-1:0]   wrEn,
    input  logic              rdEn,
    input  logic              rdZero,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] q
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Byte-lane writes; contents are deliberately untouched by reset.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (wrEn[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read register: loads only on a read, so writes never disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (rdEn) begin
            q <= rdZero ? '0 : mem[idx];
        end
    end

endmodule

// File: rtl/dmem_slave.sv
// Multi-cycle data-memory slave: IDLE -> BUSY (LATENCY cycles) -> DONE.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses as errors.
module dmem_slave
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [31:0]       addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              stall,
    output logic              resp_valid,
    output logic              addr_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    stateT             state, nextState;
    logic [CNT_W-1:0]  cnt;
    logic              weQ;
    logic [BE_W-1:0]   beQ;
    logic [31:0]       addrQ;
    logic [WORD_W-1:0] wdataQ;
    logic              errQ;
    logic              lastBusy;
    logic              accessErr;
    logic              inRange;
    logic [BE_W-1:0]   ramWrEn;
    logic              ramRdEn;

    assign inRange  = ({2'b00, addrQ[31:2]} < 32'(DEPTH));
    assign lastBusy = (state == BUSY) && (cnt == '0);

`ifdef DMEM_ALIGN_CHECK_EN
    assign accessErr = !inRange || isMisaligned(addrQ[1:0], beQ);
`else
    logic unusedAddrLo;
    assign unusedAddrLo = ^addrQ[1:0];
    assign accessErr    = !inRange;
`endif

    // Access fires on the last BUSY edge; a reset on that edge cancels it.
    assign ramWrEn = (lastBusy && weQ && !accessErr && !rst) ? beQ : '0;
    assign ramRdEn = lastBusy && !weQ && !rst;

    // Next-state and handshake outputs.
    always_comb begin
        nextState = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = req;
                if (req) nextState = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt == '0) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign resp_valid = (state == DONE);
    assign addr_err   = errQ;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Request capture, latency counter and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            weQ    <= 1'b0;
            beQ    <= '0;
            addrQ  <= '0;
            wdataQ <= '0;
            errQ   <= 1'b0;
        end else begin
            if ((state == IDLE) && req) begin
                cnt    <= CNT_W'(LATENCY - 1);
                weQ    <= we;
                beQ    <= be;
                addrQ  <= addr;
                wdataQ <= wdata;
            end else if ((state == BUSY) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (lastBusy) errQ <= accessErr;
        end
    end

    dmem_ram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) uRam (
        .clk   (clk),
        .rst   (rst),
        .wrEn  (ramWrEn),
        .rdEn  (ramRdEn),
        .rdZero(accessErr),
        .idx   (addrQ[AW+1:2]),
        .wdata (wdataQ),
        .q     (rdata)
    );

endmodule

// File: tb/tb_dmem_slave.sv
// Self-checking bench for dmem_slave: directed table, corner sequences,
// randomized accesses against a word-array reference model.
module tb_dmem_slave;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk, rst;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic        stall, resp_valid, addr_err;

    logic        bReq, bWe;
    logic [3:0]  bBe;
    logic [31:0] bAddr, bWdata, bRdata;
    logic        bStall, bResp, bErr;

    int passCnt = 0;
    int totalCnt = 0;
    int cyc = 0;

    dmem_slave #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .rdata(rdata), .stall(stall), .resp_valid(resp_valid),
        .addr_err(addr_err)
    );

    dmem_slave #(.DEPTH(DEPTH), .LATENCY(1)) dutB (
        .clk(clk), .rst(rst), .req(bReq), .we(bWe), .be(bBe), .addr(bAddr),
        .wdata(bWdata), .rdata(bRdata), .stall(bStall), .resp_valid(bResp),
        .addr_err(bErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    logic [31:0] mdl [int unsigned];
    logic [31:0] mdlRd = 32'h0;

    function automatic void modelAccess(input logic w, input logic [3:0] b,
                                        input logic [31:0] a, input logic [31:0] d,
                                        output logic err, output logic [31:0] rd);
        int unsigned wi = a / 4;
        err = (wi >= DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
        if (b == 4'hF && (a % 4) != 0) err = 1'b1;
        if ((b == 4'h3 || b == 4'hC) && (a % 2) != 0) err = 1'b1;
`endif
        if (w) begin
            if (!err) begin
                logic [31:0] cur = mdl.exists(wi) ? mdl[wi] : 32'h0;
                for (int i = 0; i < 4; i++)
                    if (b[i]) cur[8*i +: 8] = d[8*i +: 8];
                mdl[wi] = cur;
            end
        end else begin
            mdlRd = err ? 32'h0 : mdl[wi];
        end
        rd = mdlRd;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            passCnt++;
    endtask

    task automatic accessA(input logic w, input logic [3:0] b, input logic [31:0] a,
                           input logic [31:0] d, input bit holdDone,
                           output bit got, output int nStall,
                           output logic [31:0] rd, output logic err);
        @(negedge clk);
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        got = 0; nStall = 0; rd = '0; err = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (resp_valid) begin
                got = 1; rd = rdata; err = addr_err;
                break;
            end
            if (stall) nStall++;
            @(negedge clk);
        end
        if (!holdDone) req = 1'b0;
        else begin
            @(negedge clk);
            req = 1'b0;
            #1 check("done_req_ignored_stall", {31'b0, stall}, 32'h0);
            @(negedge clk);
            #1 check("done_req_ignored_busy", {30'b0, stall, resp_valid}, 32'h0);
        end
    endtask

    task automatic runA(input string name, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic expErr, input logic [31:0] expRd, input bit holdDone);
        bit got; int ns; logic [31:0] rd; logic err;
        accessA(w, b, a, d, holdDone, got, ns, rd, err);
        check({name, "_resp"}, {31'b0, got}, 32'h1);
        check({name, "_stalls"}, ns, LAT + 1);
        check({name, "_err"}, {31'b0, err}, {31'b0, expErr});
        check({name, "_rdata"}, rd, expRd);
    endtask

    task automatic accessB(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output bit got, output int nStall,
                           output logic [31:0] rd, output int respCyc);
        @(negedge clk);
        bReq = 1'b1; bWe = w; bBe = 4'hF; bAddr = a; bWdata = d;
        got = 0; nStall = 0; rd = '0; respCyc = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bResp) begin
                got = 1; rd = bRdata; respCyc = cyc;
                break;
            end
            if (bStall) nStall++;
            @(negedge clk);
        end
        bReq = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [3:0]  b;
        logic [31:0] a;
        logic [31:0] d;
        logic        expErr;
        logic [31:0] expRd;
    } vecT;

    vecT vecs [13];

    initial begin
        logic        mErr;
        logic [31:0] mRd;
        logic [31:0] word2;
        bit          got;
        int          ns, c1, c2;
        logic [31:0] rd;

        rst = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
        bReq = 1'b0; bWe = 1'b0; bBe = '0; bAddr = '0; bWdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_stall", {31'b0, stall}, 32'h0);
        check("reset_resp", {31'b0, resp_valid}, 32'h0);
        check("reset_err", {31'b0, addr_err}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        req = 1'b1;
        #1 check("idle_stall_follows_req", {31'b0, stall}, 32'h1);
        req = 1'b0;
        #1 check("idle_stall_drops", {31'b0, stall}, 32'h0);

        // Directed table with hand-computed expectations.
        vecs[0]  = '{1'b1, 4'hF, 32'h40,   32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 4'hF, 32'h40,   32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 4'h4, 32'h40,   32'h00AA0000, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 4'hF, 32'h40,   32'h0,        1'b0, 32'hDEAABEEF};
        vecs[4]  = '{1'b1, 4'hF, 32'h0,    32'h11223344, 1'b0, 32'hDEAABEEF};
        vecs[5]  = '{1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, 1'b1, 32'hDEAABEEF};
        vecs[6]  = '{1'b0, 4'hF, 32'h0,    32'h0,        1'b0, 32'h11223344};
        vecs[7]  = '{1'b0, 4'hF, 32'h1000, 32'h0,        1'b1, 32'h0};
        vecs[8]  = '{1'b1, 4'h0, 32'h0,    32'hFFFFFFFF, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 4'hF, 32'h0,    32'h0,        1'b0, 32'h11223344};
        vecs[10] = '{1'b1, 4'hF, 32'hFFC,  32'hCAFEF00D, 1'b0, 32'h11223344};
        vecs[11] = '{1'b0, 4'hF, 32'hFFC,  32'h0,        1'b0, 32'hCAFEF00D};
`ifdef DMEM_ALIGN_CHECK_EN
        vecs[12] = '{1'b0, 4'hF, 32'h42,   32'h0,        1'b1, 32'h0};
`else
        vecs[12] = '{1'b0, 4'hF, 32'h42,   32'h0,        1'b0, 32'hDEAABEEF};
`endif
        for (int i = 0; i < 13; i++) begin
            modelAccess(vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].d, mErr, mRd);
            runA($sformatf("vec%0d", i), vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].d,
                 vecs[i].expErr, vecs[i].expRd, 1'b0);
        end

        // Preload a pool of words at both ends of the array.
        for (int i = 0; i < 16; i++) begin
            int unsigned wi = (i < 8) ? i : (DEPTH - 16 + i);
            logic [31:0] v = $urandom;
            modelAccess(1'b1, 4'hF, wi * 4, v, mErr, mRd);
            runA("preload", 1'b1, 4'hF, wi * 4, v, 1'b0, mRd, 1'b0);
        end
        word2 = mdl[2];

        // Reset in the first BUSY cycle aborts a pending write.
        @(negedge clk);
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h8; wdata = 32'h12345678;
        @(negedge clk);
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_stall", {31'b0, stall}, 32'h0);
        check("abort_resp", {31'b0, resp_valid}, 32'h0);
        check("abort_rdata_cleared", rdata, 32'h0);
        mdlRd = 32'h0;
        modelAccess(1'b0, 4'hF, 32'h8, 32'h0, mErr, mRd);
        runA("abort_readback", 1'b0, 4'hF, 32'h8, 32'h0, 1'b0, word2, 1'b0);

        // req left high through DONE must not start a second access.
        modelAccess(1'b0, 4'hF, 32'h4, 32'h0, mErr, mRd);
        runA("hold_in_done", 1'b0, 4'hF, 32'h4, 32'h0, mErr, mRd, 1'b1);

        // Randomized accesses checked against the model.
        for (int n = 0; n < 80; n++) begin
            logic [3:0] beSet [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
            logic        w  = $urandom_range(0, 1);
            logic [3:0]  b  = beSet[$urandom_range(0, 7)];
            int unsigned pi = $urandom_range(0, 15);
            int unsigned wi = (pi < 8) ? pi : (DEPTH - 16 + pi);
            logic [31:0] a, d;
            if ($urandom_range(0, 7) == 0) wi = DEPTH + $urandom_range(0, 5000);
            a = wi * 4 + $urandom_range(0, 3);
            d = $urandom;
            modelAccess(w, b, a, d, mErr, mRd);
            runA($sformatf("rnd%0d", n), w, b, a, d, mErr, mRd, 1'b0);
        end

        // Back-to-back reads on the LATENCY=1 instance.
        accessB(1'b1, 32'h0, 32'hA5A5A5A5, got, ns, rd, c1);
        accessB(1'b1, 32'h4, 32'h5A5A5A5A, got, ns, rd, c1);
        accessB(1'b0, 32'h0, 32'h0, got, ns, rd, c1);
        check("b2b_first_resp", {31'b0, got}, 32'h1);
        check("b2b_first_stalls", ns, 2);
        check("b2b_first_rdata", rd, 32'hA5A5A5A5);
        accessB(1'b0, 32'h4, 32'h0, got, ns, rd, c2);
        check("b2b_second_resp", {31'b0, got}, 32'h1);
        check("b2b_second_stalls", ns, 2);
        check("b2b_second_rdata", rd, 32'h5A5A5A5A);
        check("b2b_pulse_spacing", c2 - c1, 3);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
